vl_systest_sweep_compare: RTL and testbench

//  Clocked, parametrised spec-vs-impl equivalence sweeper for VL systests.

---
 rtl/vl_systest_pkg.sv | 34 +++
 rtl/vl_systest_sweep_compare_if.sv | 46 ++++
 rtl/vl_systest_sat_ctr.sv | 30 +++
 rtl/vl_systest_sweep_compare.sv | 193 +++++++++++++++++++
 tb/tb_vl_systest_sweep_compare.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vl_systest_pkg.sv
// ---------------------------------------------------------------------------
// vl_systest_pkg
// Shared types for the VL systest spec-vs-impl sweep comparator.
//   state_t       sweep controller states
//   DIGIT_*       2-bit codes for one 4-valued stimulus digit
//   decode_digit  turns a digit code into the 4-state bit driven on stim_o
// ---------------------------------------------------------------------------
package vl_systest_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE0,
        PRE1,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0] DIGIT_ZERO = 2'd0;
    localparam logic [1:0] DIGIT_ONE  = 2'd1;
    localparam logic [1:0] DIGIT_X    = 2'd2;
    localparam logic [1:0] DIGIT_Z    = 2'd3;

    // Maps a digit code onto the value applied to one stimulus bit.
    function automatic logic decode_digit(input logic [1:0] code);
        case (code)
            DIGIT_ZERO: return 1'b0;
            DIGIT_ONE:  return 1'b1;
            DIGIT_X:    return 1'bx;
            default:    return 1'bz;
        endcase
    endfunction

endpackage

// File: rtl/vl_systest_sweep_compare_if.sv
// ---------------------------------------------------------------------------
// vl_systest_sweep_compare_if
// Bundles the control, compare and status signals of the sweep comparator.
//   master modport: test environment (drives start/chan_mask/spec_i/impl_i)
//   slave modport:  the comparator (drives stim_o and all status outputs)
// Parameters must match those given to vl_systest_sweep_compare.
// ---------------------------------------------------------------------------
interface vl_systest_sweep_compare_if #(
    parameter int IN_WIDTH   = 4,
    parameter int NUM_INPUTS = 2,
    parameter int NUM_CHANS  = 9,
    parameter int CHAN_WIDTH = 28,
    parameter int CNT_WIDTH  = 16,
    parameter int TWO_STATE  = 0
);
    localparam int D    = IN_WIDTH * NUM_INPUTS;
    localparam int IDXW = (TWO_STATE != 0) ? D : 2 * D;
    localparam int CHW  = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;

    logic                            start;
    logic [NUM_CHANS-1:0]            chan_mask;
    logic [NUM_CHANS*CHAN_WIDTH-1:0] spec_i;
    logic [NUM_CHANS*CHAN_WIDTH-1:0] impl_i;
    logic [D-1:0]                    stim_o;
    logic                            busy;
    logic                            done;
    logic                            fail_any;
    logic [NUM_CHANS-1:0]            chan_fail;
    logic [NUM_CHANS*CNT_WIDTH-1:0]  fail_count;
    logic                            first_fail_valid;
    logic [IDXW-1:0]                 first_fail_idx;
    logic [CHW-1:0]                  first_fail_chan;

    modport master (
        output start, chan_mask, spec_i, impl_i,
        input  stim_o, busy, done, fail_any, chan_fail, fail_count,
               first_fail_valid, first_fail_idx, first_fail_chan
    );

    modport slave (
        input  start, chan_mask, spec_i, impl_i,
        output stim_o, busy, done, fail_any, chan_fail, fail_count,
               first_fail_valid, first_fail_idx, first_fail_chan
    );

endinterface

// File: rtl/vl_systest_sat_ctr.sv
// ---------------------------------------------------------------------------
// vl_systest_sat_ctr
// Saturating up-counter with synchronous clear.
//   clk, rst  clock / asynchronous active-high reset
//   clear     zero the count (wins over inc)
//   inc       add one unless already all-ones
//   count     current value
// ---------------------------------------------------------------------------
module vl_systest_sat_ctr #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/vl_systest_sweep_compare.sv
// ---------------------------------------------------------------------------
// vl_systest_sweep_compare
// Sweeps every 2- or 4-valued combination onto the stimulus inputs of a
// spec/impl DUT pair, waits SETTLE_CYCLES, then case-compares each packed
// output channel. Keeps sticky per-channel fail flags, saturating mismatch
// counts and the first failing vector/channel.
//   clk, rst   clock / asynchronous active-high reset
//   bus.start, bus.chan_mask        sweep request and channel enables
//   bus.spec_i, bus.impl_i          packed DUT outputs to compare
//   bus.stim_o                      stimulus to both DUTs
//   bus.busy, bus.done              sweep status
//   bus.fail_any, bus.chan_fail, bus.fail_count, bus.first_fail_*  results
// ---------------------------------------------------------------------------
module vl_systest_sweep_compare
    import vl_systest_pkg::*;
#(
    parameter int IN_WIDTH      = 4,
    parameter int NUM_INPUTS    = 2,
    parameter int NUM_CHANS     = 9,
    parameter int CHAN_WIDTH    = 28,
    parameter int SETTLE_CYCLES = 10,
    parameter int CNT_WIDTH     = 16,
    parameter int TWO_STATE     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    vl_systest_sweep_compare_if.slave bus
);
    localparam int D    = IN_WIDTH * NUM_INPUTS;
    localparam int IDXW = (TWO_STATE != 0) ? D : 2 * D;
    localparam int CHW  = (NUM_CHANS > 1) ? $clog2(NUM_CHANS) : 1;
    localparam int SCW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SCW-1:0]  SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SCW-1:0]  SETTLE_ONE  = SCW'(1);
    localparam logic [IDXW-1:0] IDX_ONE     = IDXW'(1);

    state_t                         state;
    state_t                         next_state;
    logic [IDXW-1:0]                idx;
    logic [SCW-1:0]                 settle_cnt;
    logic [NUM_CHANS-1:0]           mask_q;
    logic [NUM_CHANS-1:0]           chan_fail_q;
    logic [NUM_CHANS-1:0]           mismatch;
    logic [CHW-1:0]                 low_chan;
    logic                           sweep_clear;
    logic                           check_en;
    logic [D-1:0]                   vec_stim;
    logic [D-1:0]                   stim;
    logic                           ff_valid;
    logic [IDXW-1:0]                ff_idx;
    logic [CHW-1:0]                 ff_chan;
    logic [NUM_CHANS*CNT_WIDTH-1:0] counts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            mask_q     <= '0;
        end else begin
            state <= next_state;
            // The index stops at all-ones so DONE keeps showing the last vector.
            if (sweep_clear) begin
                idx    <= '0;
                mask_q <= bus.chan_mask;
            end else if (check_en && (idx != '1)) begin
                idx <= idx + IDX_ONE;
            end
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SETTLE_ONE;
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    always_comb begin
        next_state  = state;
        sweep_clear = 1'b0;
        check_en    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    next_state  = PRE0;
                    sweep_clear = 1'b1;
                end
            end
            PRE0:   next_state = PRE1;
            PRE1:   next_state = SETTLE;
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = CHECK;
                end
            end
            CHECK: begin
                check_en   = 1'b1;
                next_state = (idx == '1) ? DONE : PRE0;
            end
            default: next_state = IDLE;
        endcase
    end

    // Vector decode: stim bit j is driven by index digit j, so the last
    // digit (stim LSB) changes fastest as idx counts up.
    generate
        if (TWO_STATE != 0) begin : g_two_state
            assign vec_stim = idx;
        end else begin : g_four_state
            always_comb begin
                vec_stim = '0;
                for (int j = 0; j < D; j++) begin
                    vec_stim[j] = decode_digit(idx[2*j +: 2]);
                end
            end
        end
    endgenerate

    // PRE0 then PRE1 guarantee every stimulus bit toggles before each vector.
    always_comb begin
        case (state)
            PRE0:                 stim = '0;
            PRE1:                 stim = '1;
            SETTLE, CHECK, DONE:  stim = vec_stim;
            default:              stim = '0;
        endcase
    end

    // Case inequality keeps X/Z differences visible while the result stays 0/1.
    always_comb begin
        mismatch = '0;
        for (int c = 0; c < NUM_CHANS; c++) begin
            mismatch[c] = mask_q[c] &&
                (bus.spec_i[c*CHAN_WIDTH +: CHAN_WIDTH] !== bus.impl_i[c*CHAN_WIDTH +: CHAN_WIDTH]);
        end
    end

    always_comb begin
        low_chan = '0;
        for (int c = NUM_CHANS - 1; c >= 0; c--) begin
            if (mismatch[c]) begin
                low_chan = CHW'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_fail_q <= '0;
            ff_valid    <= 1'b0;
            ff_idx      <= '0;
            ff_chan     <= '0;
        end else if (sweep_clear) begin
            chan_fail_q <= '0;
            ff_valid    <= 1'b0;
            ff_idx      <= '0;
            ff_chan     <= '0;
        end else if (check_en) begin
            chan_fail_q <= chan_fail_q | mismatch;
            if (!ff_valid && (|mismatch)) begin
                ff_valid <= 1'b1;
                ff_idx   <= idx;
                ff_chan  <= low_chan;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CHANS; g++) begin : g_chan
            vl_systest_sat_ctr #(
                .CNT_WIDTH(CNT_WIDTH)
            ) u_ctr (
                .clk  (clk),
                .rst  (rst),
                .clear(sweep_clear),
                .inc  (check_en && mismatch[g]),
                .count(counts[g*CNT_WIDTH +: CNT_WIDTH])
            );
        end
    endgenerate

    assign bus.stim_o           = stim;
    assign bus.busy             = (state == PRE0) || (state == PRE1) ||
                                  (state == SETTLE) || (state == CHECK);
    assign bus.done             = (state == DONE);
    assign bus.chan_fail        = chan_fail_q;
    assign bus.fail_any         = |chan_fail_q;
    assign bus.fail_count       = counts;
    assign bus.first_fail_valid = ff_valid;
    assign bus.first_fail_idx   = ff_idx;
    assign bus.first_fail_chan  = ff_chan;

endmodule

// File: tb/tb_vl_systest_sweep_compare.sv
// ---------------------------------------------------------------------------
// tb_vl_systest_sweep_compare
// Drives three comparator instances (4-state/16-bit counts, 2-state, and
// 4-state/2-bit counts) with IN_WIDTH=2, NUM_INPUTS=1, NUM_CHANS=2,
// CHAN_WIDTH=4, SETTLE_CYCLES=2. Per-vector fault tables decide where impl
// differs from the random spec data; a scoreboard queue holds the expected
// sweep result and a monitor compares when done rises.
// ---------------------------------------------------------------------------
module tb_vl_systest_sweep_compare;

    localparam int CPV = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vl_systest_sweep_compare_if #(.IN_WIDTH(2), .NUM_INPUTS(1), .NUM_CHANS(2),
        .CHAN_WIDTH(4), .CNT_WIDTH(16), .TWO_STATE(0)) if_a ();
    vl_systest_sweep_compare_if #(.IN_WIDTH(2), .NUM_INPUTS(1), .NUM_CHANS(2),
        .CHAN_WIDTH(4), .CNT_WIDTH(16), .TWO_STATE(1)) if_b ();
    vl_systest_sweep_compare_if #(.IN_WIDTH(2), .NUM_INPUTS(1), .NUM_CHANS(2),
        .CHAN_WIDTH(4), .CNT_WIDTH(2), .TWO_STATE(0)) if_c ();

    vl_systest_sweep_compare #(.IN_WIDTH(2), .NUM_INPUTS(1), .NUM_CHANS(2),
        .CHAN_WIDTH(4), .SETTLE_CYCLES(2), .CNT_WIDTH(16), .TWO_STATE(0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    vl_systest_sweep_compare #(.IN_WIDTH(2), .NUM_INPUTS(1), .NUM_CHANS(2),
        .CHAN_WIDTH(4), .SETTLE_CYCLES(2), .CNT_WIDTH(16), .TWO_STATE(1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    vl_systest_sweep_compare #(.IN_WIDTH(2), .NUM_INPUTS(1), .NUM_CHANS(2),
        .CHAN_WIDTH(4), .SETTLE_CYCLES(2), .CNT_WIDTH(2), .TWO_STATE(0))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    typedef struct {
        int         cycles;
        logic [1:0] cf;
        logic [15:0] cnt0;
        logic [15:0] cnt1;
        logic       ffv;
        logic [3:0] ffi;
        logic       ffc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         sel = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    bit         running = 1'b0;
    logic [1:0] fault_tbl [16];

    logic        m_busy, m_done, m_fa, m_ffv, m_ffc;
    logic [1:0]  m_stim, m_cf;
    logic [15:0] m_cnt0, m_cnt1;
    logic [3:0]  m_ffi;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe whichever instance the current test is exercising.
    always_comb begin
        case (sel)
            1: begin
                m_busy = if_b.busy; m_done = if_b.done; m_fa = if_b.fail_any;
                m_stim = if_b.stim_o; m_cf = if_b.chan_fail;
                m_cnt0 = if_b.fail_count[15:0]; m_cnt1 = if_b.fail_count[31:16];
                m_ffv = if_b.first_fail_valid; m_ffi = {2'b00, if_b.first_fail_idx};
                m_ffc = if_b.first_fail_chan;
            end
            2: begin
                m_busy = if_c.busy; m_done = if_c.done; m_fa = if_c.fail_any;
                m_stim = if_c.stim_o; m_cf = if_c.chan_fail;
                m_cnt0 = {14'd0, if_c.fail_count[1:0]}; m_cnt1 = {14'd0, if_c.fail_count[3:2]};
                m_ffv = if_c.first_fail_valid; m_ffi = if_c.first_fail_idx;
                m_ffc = if_c.first_fail_chan;
            end
            default: begin
                m_busy = if_a.busy; m_done = if_a.done; m_fa = if_a.fail_any;
                m_stim = if_a.stim_o; m_cf = if_a.chan_fail;
                m_cnt0 = if_a.fail_count[15:0]; m_cnt1 = if_a.fail_count[31:16];
                m_ffv = if_a.first_fail_valid; m_ffi = if_a.first_fail_idx;
                m_ffc = if_a.first_fail_chan;
            end
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sweep outcome from the rules: walk every vector, count masked faults.
    function automatic exp_t buildExpect(input int s, input logic [1:0] mask);
        exp_t e;
        int nvec, cmax;
        int cnt [2];
        nvec = (s == 1) ? 4 : 16;
        cmax = (s == 2) ? 3 : 65535;
        cnt[0] = 0; cnt[1] = 0;
        e.cycles = nvec * CPV;
        e.cf = 2'b00; e.ffv = 1'b0; e.ffi = 4'd0; e.ffc = 1'b0;
        for (int v = 0; v < nvec; v++) begin
            for (int c = 0; c < 2; c++) begin
                if (fault_tbl[v][c] && mask[c]) begin
                    if (cnt[c] < cmax) cnt[c]++;
                    e.cf[c] = 1'b1;
                    if (!e.ffv) begin
                        e.ffv = 1'b1; e.ffi = 4'(v); e.ffc = 1'(c);
                    end
                end
            end
        end
        e.cnt0 = 16'(cnt[0]);
        e.cnt1 = 16'(cnt[1]);
        return e;
    endfunction

    task automatic setFaults(input logic [1:0] pat);
        for (int v = 0; v < 16; v++) fault_tbl[v] = pat;
    endtask

    task automatic randomFaults(input int odds);
        for (int v = 0; v < 16; v++)
            for (int c = 0; c < 2; c++)
                fault_tbl[v][c] = ($urandom_range(0, odds - 1) == 0);
    endtask

    task automatic applyStimulus(input int s, input logic [1:0] mask);
        @(negedge clk);
        sel = s;
        case (s)
            1:       begin if_b.chan_mask = mask; if_b.start = 1'b1; end
            2:       begin if_c.chan_mask = mask; if_c.start = 1'b1; end
            default: begin if_a.chan_mask = mask; if_a.start = 1'b1; end
        endcase
        exp_q.push_back(buildExpect(s, mask));
        @(posedge clk);
        #1;
        if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
        // The mask is latched at start; later changes must not matter.
        if_a.chan_mask = ~mask; if_b.chan_mask = ~mask; if_c.chan_mask = ~mask;
        start_cyc = cyc;
        running = 1'b1;
        checkOutput("start_busy", {31'd0, m_busy}, 32'd1);
        checkOutput("start_done_clear", {31'd0, m_done}, 32'd0);
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", {31'd0, exp_q.size() == 0}, 32'd1);
        exp_q.delete();
        running = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkIdleState(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, m_busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, m_done}, 32'd0);
        checkOutput({tag, "_fail_any"}, {31'd0, m_fa}, 32'd0);
        checkOutput({tag, "_stim"}, {30'd0, m_stim}, 32'd0);
        checkOutput({tag, "_chan_fail"}, {30'd0, m_cf}, 32'd0);
        checkOutput({tag, "_cnt0"}, {16'd0, m_cnt0}, 32'd0);
        checkOutput({tag, "_cnt1"}, {16'd0, m_cnt1}, 32'd0);
        checkOutput({tag, "_ff_valid"}, {31'd0, m_ffv}, 32'd0);
        checkOutput({tag, "_ff_idx"}, {28'd0, m_ffi}, 32'd0);
    endtask

    // Spec/impl data: random spec every cycle, impl flipped where the fault
    // table marks the vector currently being presented.
    initial begin : driver
        int v;
        logic [7:0] sp, im;
        forever begin
            @(negedge clk);
            v = (cyc - start_cyc) / CPV;
            sp = 8'($urandom);
            im = sp;
            if (running && v < 16) begin
                for (int c = 0; c < 2; c++)
                    if (fault_tbl[v][c]) im[c*4 +: 4] = sp[c*4 +: 4] ^ 4'($urandom_range(1, 15));
            end
            if_a.spec_i = sp; if_a.impl_i = im;
            if_b.spec_i = sp; if_b.impl_i = im;
            if_c.spec_i = sp; if_c.impl_i = im;
        end
    end

    initial begin : monitor
        exp_t e;
        logic prev_done;
        logic [1:0] ex, known;
        int k, v, d;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (running && !rst && exp_q.size() > 0) begin
                k = cyc - start_cyc;
                if (k < exp_q[0].cycles) begin
                    v = k / CPV;
                    ex = 2'b00;
                    known = 2'b11;
                    if (k % CPV == 1) begin
                        ex = 2'b11;
                    end else if (k % CPV >= 2) begin
                        if (sel == 1) begin
                            ex = 2'(v);
                        end else begin
                            for (int j = 0; j < 2; j++) begin
                                d = (v / (4 ** j)) % 4;
                                if (d < 2) ex[j] = d[0];
                                else known[j] = 1'b0;
                            end
                        end
                    end
                    checkOutput("stim", {30'd0, m_stim & known}, {30'd0, ex & known});
                end
                if (m_done && !prev_done) begin
                    e = exp_q.pop_front();
                    checkOutput("done_cycles", k, e.cycles);
                    checkOutput("busy_at_done", {31'd0, m_busy}, 32'd0);
                    checkOutput("chan_fail", {30'd0, m_cf}, {30'd0, e.cf});
                    checkOutput("fail_any", {31'd0, m_fa}, {31'd0, |e.cf});
                    checkOutput("fail_count0", {16'd0, m_cnt0}, {16'd0, e.cnt0});
                    checkOutput("fail_count1", {16'd0, m_cnt1}, {16'd0, e.cnt1});
                    checkOutput("first_fail_valid", {31'd0, m_ffv}, {31'd0, e.ffv});
                    checkOutput("first_fail_idx", {28'd0, m_ffi}, {28'd0, e.ffi});
                    checkOutput("first_fail_chan", {31'd0, m_ffc}, {31'd0, e.ffc});
                    running = 1'b0;
                end
            end
            prev_done = m_done;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        rst = 1'b1;
        if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0;
        if_a.chan_mask = 2'b00; if_b.chan_mask = 2'b00; if_c.chan_mask = 2'b00;
        setFaults(2'b00);
        repeat (3) @(negedge clk);
        sel = 0; #1 checkIdleState("reset_a");
        sel = 1; #1 checkIdleState("reset_b");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] equal outputs, full 4-state sweep");
        setFaults(2'b00);
        applyStimulus(0, 2'b11);
        waitDone(200);

        $display("[TB] chan1 differs on vector 6 only");
        setFaults(2'b00);
        fault_tbl[6] = 2'b10;
        applyStimulus(0, 2'b11);
        waitDone(200);

        $display("[TB] same fault with chan1 masked off");
        applyStimulus(0, 2'b01);
        waitDone(200);

        $display("[TB] two-state sweep");
        setFaults(2'b00);
        applyStimulus(1, 2'b11);
        waitDone(100);

        $display("[TB] random faults");
        for (int r = 0; r < 3; r++) begin
            randomFaults(4);
            applyStimulus(0, 2'($urandom));
            waitDone(200);
        end
        randomFaults(2);
        applyStimulus(1, 2'($urandom));
        waitDone(100);

        $display("[TB] reset mid-sweep");
        setFaults(2'b11);
        applyStimulus(0, 2'b11);
        n = 0;
        while ((cyc - start_cyc) < 37 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        #1;
        running = 1'b0;
        exp_q.delete();
        checkIdleState("midreset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        randomFaults(3);
        applyStimulus(0, 2'b11);
        waitDone(200);

        $display("[TB] saturating counter with ignored start pulses");
        setFaults(2'b01);
        applyStimulus(2, 2'b11);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(5, 15)) @(negedge clk);
            if_c.start = 1'b1;
            @(negedge clk);
            if_c.start = 1'b0;
        end
        waitDone(200);

        randomFaults(2);
        applyStimulus(2, 2'($urandom));
        waitDone(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
